switch_nport_rr: RTL and testbench
==================================

// Module: switch_nport_rr
// PURPOSE
//  Parametrised N-port packet switch: per-input FIFO buffering, per-output round-robin arbitration,
//  valid/ready backpressure on both sides, one registered output stage per port.
//  Next-generation top of the switch datapath; ports are packed arrays, not port_if.
// PARAMETERS
//  NUM_PORTS   4   port count (2..8); also the width of the one-hot source/target fields
//  DATA_WIDTH  8   payload width
//  FIFO_DEPTH  4   entries per input FIFO; power of two, >=2
// PORTS
//  clk          in   1                        single clock, rising edge
//  rst_n        in   1                        asynchronous active-low reset
//  in_valid     in   [NUM_PORTS]              ingress packet valid, per port
//  in_ready     out  [NUM_PORTS]              ingress FIFO can accept
//  in_source    in   [NUM_PORTS][NUM_PORTS]   one-hot source id
//  in_target    in   [NUM_PORTS][NUM_PORTS]   one-hot destination
//  in_data      in   [NUM_PORTS][DATA_WIDTH]  payload
//  out_valid    out  [NUM_PORTS]              egress packet valid
//  out_ready    in   [NUM_PORTS]              egress sink accepts
//  out_source   out  [NUM_PORTS][NUM_PORTS]   source of delivered packet
//  out_target   out  [NUM_PORTS][NUM_PORTS]   target of delivered packet (== one-hot of port)
//  out_data     out  [NUM_PORTS][DATA_WIDTH]  payload
//  drop_count   out  [NUM_PORTS][16]          per-input illegal-packet count (STATS_EN)
//  tx_count     out  [NUM_PORTS][16]          per-output delivered-packet count (STATS_EN)
// BEHAVIOUR
//  Reset (async, rst_n low): FIFOs emptied, out_valid=0, out_* fields=0, RR pointers=0, counters=0;
//   in_ready=0 while rst_n low, =1 from first edge after release. Reset mid-packet discards all state.
//  Ingress: accept when in_valid&&in_ready at rising edge. in_ready = !fifo_full (no same-cycle
//   pop-to-push bypass: a full FIFO stays not-ready even if popped that cycle).
//  Legality: target must be exactly one-hot and source must be exactly one-hot; otherwise the
//   packet is handshaken (consumed) but not written, and drop_count[i] increments.
//   Target == source is legal (loopback).
//  Arbitration, per output o: requesters = inputs with non-empty FIFO whose head targets o.
//   Output register "free" = !out_valid[o] || out_ready[o]. When free and any request: winner = first
//   requester at or after rr_ptr[o] (wrapping NUM_PORTS-1 -> 0); head popped, loaded into out register,
//   rr_ptr[o] <= winner+1 (mod NUM_PORTS). No request or not free: rr_ptr unchanged.
//  Each FIFO head names one output, so an input is popped by at most one output per cycle.
//  Egress: out_* held stable while out_valid && !out_ready. Back-to-back: a new packet loads in the
//   same cycle the previous one handshakes -> one packet/cycle/output sustained.
//  Latency: accepted at edge t -> out_valid at edge t+2 when uncontended and output free.
//  Head-of-line blocking is accepted: a blocked head stalls its whole FIFO.
//  Ordering: packets from one input to one output are delivered in arrival order.
// CONFIGURATION
//  SWITCH_NPORT_STATS_EN defined: drop_count[i]++ per illegal packet, tx_count[o]++ per out handshake;
//   both 16-bit, saturate at 16'hFFFF. Undefined: counter logic absent, both ports tied to 0.
//   Drop/forward behaviour identical in both builds.
// STRUCTURE
//  packet_pkg: NUM_PORTS/DATA_WIDTH/FIFO_DEPTH defaults, STAT_WIDTH=16, function is_onehot().
//  Sub-module rr_arbiter (REQ_WIDTH): req, ptr in -> one-hot grant + winner index; one instance per output.
//  Input FIFOs: inline generate loop (pointer-based, extra wrap bit for full/empty).
// TESTING
//  1. Port0 sends target 4'b0100, data 8'hA5, out_ready=1 -> out_valid[2] at edge t+2, data A5, src 0001.
//  2. Ports 0,1,3 all target port 2 every cycle -> grants 0,1,3,0,1,3...; one packet per cycle on port 2.
//  3. out_ready[1]=0, port0 streams to port1 -> 4 accepted + 1 in out reg, in_ready[0]=0; release -> 5 in order.
//  4. target 4'b0110 and 4'b0000 on port3 -> not delivered anywhere; STATS_EN build: drop_count[3]==2.
//  5. Assert rst_n low with 3 packets queued -> out_valid=0 immediately, nothing delivered after release.
//  6. NUM_PORTS=8, FIFO_DEPTH=8 random legal traffic + random out_ready -> scoreboard: no loss, per-pair order.

Source files
------------

// File: rtl/packet_pkg.sv
// ----------------------------------------------------------------------------
// packet_pkg
//   Shared defaults and helpers for the switch_nport_rr datapath.
//   - DEF_NUM_PORTS / DEF_DATA_WIDTH / DEF_FIFO_DEPTH : default geometry
//   - STAT_WIDTH : width of the per-port statistics counters
//   - is_onehot() : legality check for one-hot source/target fields
//   - sat_inc()   : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package packet_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int STAT_WIDTH     = 16;

  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  // Callers zero-extend their field to 32 bits, so this works for any port
  // count up to 32 without a width parameter.
  function automatic logic is_onehot(input logic [31:0] v);
    int cnt;
    cnt = 0;
    for (int b = 0; b < 32; b++) begin
      cnt = cnt + (v[b] ? 1 : 0);
    end
    return (cnt == 1);
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == STAT_MAX) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin selector: picks the first asserted request at
//   or after ptr, wrapping from REQ_WIDTH-1 back to 0.
//   Ports:
//     req    in  [REQ_WIDTH]  request vector
//     ptr    in  [PW]         highest-priority index this cycle
//     grant  out [REQ_WIDTH]  one-hot grant (all zero when no request)
//     winner out [PW]         index of the granted requester
//     any    out 1            at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int REQ_WIDTH = 4,
  localparam int PW = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1
) (
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [REQ_WIDTH-1:0] grant,
  output logic [PW-1:0]        winner,
  output logic                 any
);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    // Scan from ptr upward; the extra bit in sum lets the wrap be a subtract.
    for (int k = 0; k < REQ_WIDTH; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(REQ_WIDTH)) begin
        sum = sum - (PW+1)'(REQ_WIDTH);
      end
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/switch_nport_rr.sv
// ----------------------------------------------------------------------------
// switch_nport_rr
//   N-port packet switch: one FIFO per input, one round-robin arbiter and one
//   registered output stage per output, valid/ready on both sides.
//   Optional statistics: define SWITCH_NPORT_STATS_EN to enable drop_count /
//   tx_count; otherwise both outputs are tied to zero.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     in_valid/in_ready   [N]          ingress handshake
//     in_source/in_target [N][N]       one-hot source / destination
//     in_data             [N][DW]      ingress payload
//     out_valid/out_ready [N]          egress handshake
//     out_source/out_target [N][N]     fields of the delivered packet
//     out_data            [N][DW]      egress payload
//     drop_count          [N][16]      per-input illegal packet count
//     tx_count            [N][16]      per-output delivered packet count
// ----------------------------------------------------------------------------
module switch_nport_rr
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PORTS-1:0]                   in_valid,
  output logic [NUM_PORTS-1:0]                   in_ready,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    in_source,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    in_target,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   in_data,
  output logic [NUM_PORTS-1:0]                   out_valid,
  input  logic [NUM_PORTS-1:0]                   out_ready,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    out_source,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    out_target,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   out_data,
  output logic [NUM_PORTS-1:0][STAT_WIDTH-1:0]   drop_count,
  output logic [NUM_PORTS-1:0][STAT_WIDTH-1:0]   tx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // FIFO entry layout: {source, target, data}
  localparam int EW = 2*NUM_PORTS + DATA_WIDTH;

  logic [NUM_PORTS-1:0][FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [NUM_PORTS-1:0][AW:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                                         ready_en_q, ready_en_d;
  logic [NUM_PORTS-1:0]                         fifo_full, fifo_empty, legal, push, pop;
  logic [NUM_PORTS-1:0][EW-1:0]                 head;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          head_target;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          req_mat, grant;
  logic [NUM_PORTS-1:0][PW-1:0]                 winner, rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                         any_req, fire;

  logic [NUM_PORTS-1:0]                         out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          out_source_q, out_source_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          out_target_q, out_target_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]         out_data_q, out_data_d;

  // ---------------------------------------------------------------- ingress
  // in_ready is held low during reset and comes up on the first edge after
  // release; ready_en_q provides that one-edge delay.
  assign ready_en_d = 1'b1;
  assign in_ready   = {NUM_PORTS{ready_en_q}} & ~fifo_full;
  // Illegal packets complete the handshake but are never written.
  assign push       = in_valid & in_ready & legal;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    assign fifo_empty[i]  = (wr_ptr_q[i] == rd_ptr_q[i]);
    assign fifo_full[i]   = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                            (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    assign head[i]        = mem_q[i][rd_ptr_q[i][AW-1:0]];
    assign head_target[i] = head[i][DATA_WIDTH +: NUM_PORTS];
    assign legal[i]       = is_onehot(32'(in_target[i])) && is_onehot(32'(in_source[i]));
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = {in_source[i], in_target[i], in_data[i]};
        wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(1);
      end
    end
  end

  // ------------------------------------------------------------ arbitration
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_mat[o][i] = !fifo_empty[i] && head_target[i][o];
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(.REQ_WIDTH(NUM_PORTS)) u_arb (
      .req    (req_mat[o]),
      .ptr    (rr_ptr_q[o]),
      .grant  (grant[o]),
      .winner (winner[o]),
      .any    (any_req[o])
    );
    // The output register can take a new packet when empty or when its
    // current packet leaves this cycle (back-to-back throughput).
    assign fire[o] = any_req[o] && (!out_valid_q[o] || out_ready[o]);
  end

  // A head targets exactly one output, so grants never overlap per input.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (fire[o]) pop = pop | grant[o];
    end
  end

  // ----------------------------------------------------------------- egress
  always_comb begin
    out_valid_d  = out_valid_q;
    out_source_d = out_source_q;
    out_target_d = out_target_q;
    out_data_d   = out_data_q;
    rr_ptr_d     = rr_ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (fire[o]) begin
        out_valid_d[o]  = 1'b1;
        out_source_d[o] = head[winner[o]][EW-1 -: NUM_PORTS];
        out_target_d[o] = head[winner[o]][DATA_WIDTH +: NUM_PORTS];
        out_data_d[o]   = head[winner[o]][DATA_WIDTH-1:0];
        rr_ptr_d[o]     = (winner[o] == PW'(NUM_PORTS-1)) ? '0 : winner[o] + PW'(1);
      end else if (out_ready[o]) begin
        out_valid_d[o]  = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= '0;
      out_source_q <= '0;
      out_target_q <= '0;
      out_data_q   <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_source_q <= out_source_d;
      out_target_q <= out_target_d;
      out_data_q   <= out_data_d;
    end
  end

  // Storage is only read when the pointers say it holds data, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = out_valid_q;
  assign out_source = out_source_q;
  assign out_target = out_target_q;
  assign out_data   = out_data_q;

  // -------------------------------------------------------------- statistics
`ifdef SWITCH_NPORT_STATS_EN
  logic [NUM_PORTS-1:0][STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [NUM_PORTS-1:0]                 drop;

  assign drop = in_valid & in_ready & ~legal;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (drop[i])                        drop_cnt_d[i] = sat_inc(drop_cnt_q[i]);
      if (out_valid_q[i] && out_ready[i]) tx_cnt_d[i]   = sat_inc(tx_cnt_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign tx_count   = tx_cnt_q;
`else
  assign drop_count = '0;
  assign tx_count   = '0;
`endif

endmodule

// File: tb/tb_switch_nport_rr.sv
module tb_switch_nport_rr;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-port instance
  logic [3:0]          iv4, ir4, ov4, or4;
  logic [3:0][3:0]     is4, it4, os4, ot4;
  logic [3:0][DW-1:0]  id4, od4;
  logic [3:0][15:0]    dc4, tc4;

  // 8-port instance
  logic [7:0]          iv8, ir8, ov8, or8;
  logic [7:0][7:0]     is8, it8, os8, ot8;
  logic [7:0][DW-1:0]  id8, od8;
  logic [7:0][15:0]    dc8, tc8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] data;
  } sb_t;

  switch_nport_rr #(.NUM_PORTS(4), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_source(is4), .in_target(it4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_source(os4), .out_target(ot4), .out_data(od4),
    .drop_count(dc4), .tx_count(tc4)
  );

  switch_nport_rr #(.NUM_PORTS(8), .DATA_WIDTH(DW), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_source(is8), .in_target(it8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_source(os8), .out_target(ot8), .out_data(od8),
    .drop_count(dc8), .tx_count(tc8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    iv4 = '0; iv8 = '0; or4 = '1; or8 = '1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    iv4 = '0; iv8 = '0; or4 = '1; or8 = '1;
    is4 = '0; it4 = '0; id4 = '0; is8 = '0; it8 = '0; id8 = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL reset_out_valid got %h exp 0", ov4); end
    checks++; if (ir4 !== 4'h0) begin errors++; $display("FAIL reset_in_ready got %h exp 0", ir4); end
    checks++; if ({os4, ot4, od4} !== '0) begin errors++; $display("FAIL reset_out_fields got %h exp 0", {os4, ot4, od4}); end
    checks++; if ({dc4, tc4} !== '0) begin errors++; $display("FAIL reset_counters got %h exp 0", {dc4, tc4}); end
    rst_n = 1'b1;
    #1;
    checks++; if (ir4 !== 4'h0) begin errors++; $display("FAIL release_before_edge_in_ready got %h exp 0", ir4); end
    tick();
    checks++; if (ir4 !== 4'hF) begin errors++; $display("FAIL release_in_ready4 got %h exp f", ir4); end
    checks++; if (ir8 !== 8'hFF) begin errors++; $display("FAIL release_in_ready8 got %h exp ff", ir8); end
  endtask

  task automatic test_single;
    apply_reset();
    is4[0] = 4'b0001; it4[0] = 4'b0100; id4[0] = 8'hA5; iv4[0] = 1'b1;
    checks++; if (ir4[0] !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", ir4[0]); end
    tick();                                   // edge t: accepted into FIFO 0
    iv4[0] = 1'b0;
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL single_early_valid got %h exp 0", ov4); end
    tick();                                   // edge t+1: loaded into output 2
    checks++; if (ov4 !== 4'b0100) begin errors++; $display("FAIL single_valid got %b exp 0100", ov4); end
    checks++; if (od4[2] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", od4[2]); end
    checks++; if (os4[2] !== 4'b0001) begin errors++; $display("FAIL single_source got %b exp 0001", os4[2]); end
    checks++; if (ot4[2] !== 4'b0100) begin errors++; $display("FAIL single_target got %b exp 0100", ot4[2]); end
    tick();                                   // edge t+2: handshake
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL single_after_hs got %h exp 0", ov4); end
  endtask

  task automatic test_rr;
    int ports[3];
    int k, first, last, p;
    ports[0] = 0; ports[1] = 1; ports[2] = 3;
    k = 0; first = -1; last = -1;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      for (int j = 0; j < 3; j++) begin
        p = ports[j];
        iv4[p] = (c < 3);
        is4[p] = 4'b0001 << p;
        it4[p] = 4'b0100;
        id4[p] = {4'(p), 4'(c)};
      end
      tick();
      if (ov4[2]) begin
        p = ports[k % 3];
        checks++;
        if (os4[2] !== (4'b0001 << p) || od4[2] !== {4'(p), 4'(k / 3)}) begin
          errors++;
          $display("FAIL rr_order k=%0d got src %b data %h exp src %b data %h",
                   k, os4[2], od4[2], 4'b0001 << p, {4'(p), 4'(k / 3)});
        end
        if (first < 0) first = c;
        last = c;
        k++;
      end
    end
    checks++; if (k !== 9) begin errors++; $display("FAIL rr_count got %0d exp 9", k); end
    checks++; if (last - first !== 8) begin errors++; $display("FAIL rr_throughput span got %0d exp 8", last - first); end
  endtask

  task automatic test_backpressure;
    int sent, got;
    logic acc;
    apply_reset();
    or4 = 4'b1101;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      iv4[0] = 1'b1; is4[0] = 4'b0001; it4[0] = 4'b0010; id4[0] = 8'h30 + 8'(sent);
      acc = ir4[0];
      tick();
      if (acc) sent++;
    end
    iv4[0] = 1'b0;
    checks++; if (sent !== 5) begin errors++; $display("FAIL bp_accepted got %0d exp 5", sent); end
    checks++; if (ir4[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", ir4[0]); end
    checks++; if (ov4[1] !== 1'b1 || od4[1] !== 8'h30) begin errors++; $display("FAIL bp_held got v%b %h exp v1 30", ov4[1], od4[1]); end
    or4 = 4'hF;
    got = 0;
    for (int c = 0; c < 15 && got < 5; c++) begin
      if (ov4[1]) begin
        checks++;
        if (od4[1] !== 8'h30 + 8'(got)) begin
          errors++; $display("FAIL bp_order idx %0d got %h exp %h", got, od4[1], 8'h30 + 8'(got));
        end
        got++;
      end
      tick();
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_drained got %0d exp 5", got); end
  endtask

  task automatic test_illegal;
    logic [3:0] vs[4], vt[4];
    int other, loop;
    vs[0] = 4'b1000; vt[0] = 4'b0110;
    vs[1] = 4'b1000; vt[1] = 4'b0000;
    vs[2] = 4'b1001; vt[2] = 4'b0001;
    vs[3] = 4'b1000; vt[3] = 4'b1000;   // loopback, legal
    other = 0; loop = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      iv4[3] = (c < 4);
      if (c < 4) begin
        is4[3] = vs[c]; it4[3] = vt[c]; id4[3] = 8'h11 * 8'(c + 1);
        checks++; if (ir4[3] !== 1'b1) begin errors++; $display("FAIL illegal_in_ready v%0d got %b exp 1", c, ir4[3]); end
      end
      tick();
      if (ov4[2:0] !== 3'b000) other++;
      if (ov4[3]) begin
        loop++;
        checks++; if (od4[3] !== 8'h44) begin errors++; $display("FAIL loopback_data got %h exp 44", od4[3]); end
      end
    end
    checks++; if (other !== 0) begin errors++; $display("FAIL illegal_delivered got %0d exp 0", other); end
    checks++; if (loop !== 1) begin errors++; $display("FAIL loopback_count got %0d exp 1", loop); end
`ifdef SWITCH_NPORT_STATS_EN
    checks++; if (dc4 !== {16'd3, 16'd0, 16'd0, 16'd0}) begin errors++; $display("FAIL drop_count got %h exp 3 on port 3", dc4); end
    checks++; if (tc4 !== {16'd1, 16'd0, 16'd0, 16'd0}) begin errors++; $display("FAIL tx_count got %h exp 1 on port 3", tc4); end
`else
    checks++; if ({dc4, tc4} !== '0) begin errors++; $display("FAIL stats_tied got %h exp 0", {dc4, tc4}); end
`endif
  endtask

  task automatic test_reset_mid;
    int seen;
    apply_reset();
    or4 = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      iv4[0] = 1'b1; is4[0] = 4'b0001; it4[0] = 4'b0100; id4[0] = 8'h50 + 8'(c);
      tick();
    end
    iv4[0] = 1'b0;
    checks++; if (ov4[2] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", ov4[2]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL mid_async_valid got %h exp 0", ov4); end
    checks++; if (ir4 !== 4'h0) begin errors++; $display("FAIL mid_async_ready got %h exp 0", ir4); end
    checks++; if (od4[2] !== 8'h00) begin errors++; $display("FAIL mid_async_data got %h exp 0", od4[2]); end
    tick();
    rst_n = 1'b1;
    or4 = 4'hF;
    tick();
    checks++; if (ir4 !== 4'hF) begin errors++; $display("FAIL mid_release_ready got %h exp f", ir4); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov4 !== 4'h0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale_delivery got %0d exp 0", seen); end
  endtask

  task automatic test_random;
    sb_t sb[$];
    int gen, dlv, cyc, idx, tx_sum;
    logic [7:0] tag, acc, hs;
    gen = 0; dlv = 0; cyc = 0; tag = 8'h00;
    apply_reset();
    while ((gen < 200 || sb.size() != 0 || iv8 != 8'h00) && cyc < 5000) begin
      for (int p = 0; p < 8; p++) begin
        if (!iv8[p] && gen < 200 && $urandom_range(0, 1) == 1) begin
          iv8[p] = 1'b1;
          is8[p] = 8'h01 << p;
          it8[p] = 8'h01 << $urandom_range(0, 7);
          id8[p] = tag;
          tag = tag + 8'h01;
          gen++;
        end
      end
      or8 = (gen < 200) ? 8'($urandom_range(0, 255)) : 8'hFF;
      acc = iv8 & ir8;
      hs  = ov8 & or8;
      for (int o = 0; o < 8; o++) begin
        if (hs[o]) begin
          dlv++;
          checks++;
          if (ot8[o] !== (8'h01 << o)) begin
            errors++; $display("FAIL rand_target port %0d got %h exp %h", o, ot8[o], 8'h01 << o);
          end
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && sb[j].src == os8[o] && sb[j].dst == ot8[o]) idx = j;
          end
          checks++;
          if (idx < 0) begin
            errors++; $display("FAIL rand_unexpected port %0d got src %h data %h exp none", o, os8[o], od8[o]);
          end else begin
            if (sb[idx].data !== od8[o]) begin
              errors++; $display("FAIL rand_order port %0d got %h exp %h", o, od8[o], sb[idx].data);
            end
            sb.delete(idx);
          end
        end
      end
      tick();
      for (int p = 0; p < 8; p++) begin
        if (acc[p]) begin
          sb.push_back('{src: is8[p], dst: it8[p], data: id8[p]});
          iv8[p] = 1'b0;
        end
      end
      cyc++;
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL rand_lost got %0d exp 0", sb.size()); end
    checks++; if (dlv !== 200) begin errors++; $display("FAIL rand_delivered got %0d exp 200", dlv); end
    tx_sum = 0;
    for (int o = 0; o < 8; o++) tx_sum += int'(tc8[o]);
`ifdef SWITCH_NPORT_STATS_EN
    checks++; if (tx_sum !== 200) begin errors++; $display("FAIL rand_tx_sum got %0d exp 200", tx_sum); end
`else
    checks++; if (tx_sum !== 0) begin errors++; $display("FAIL rand_tx_tied got %0d exp 0", tx_sum); end
`endif
    checks++; if (dc8 !== '0) begin errors++; $display("FAIL rand_drops got %h exp 0", dc8); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
